// File: rtl/ro_sweep_ctrl.sv
// ro_sweep_ctrl: measurement sequencer for a bank of ring-oscillator sensor cells that share
// one edge counter. For each unmasked RO, in ascending index order, it selects the cell,
// clears the counter, runs the RO to let it settle, and opens the counting gate for
// WINDOW_CYC reference clocks. It then stops the RO, waits for the asynchronous counter to
// ripple out, and captures the count. A sweep runs once per i_Start, or repeats continuously.
//
// Ports
//   i_Clk, i_Rst     reference clock (rising edge), asynchronous active-high reset
//   i_Start          begin one sweep; honoured only while idle
//   i_Continuous     restart the sweep automatically at its end (sampled in END only)
//   i_Mask           per-RO include bits, latched at each sweep start
//   i_Cnt_Value      shared counter value, sampled in CAPTURE
//   o_RO_Enable      enable of the selected RO cell
//   o_RO_Sel         one-hot RO select
//   o_Cnt_Clr        synchronous clear request to the shared counter
//   o_Cnt_Gate       counter gate (counter accumulates only while high)
//   o_Result         last captured count
//   o_Result_Idx     RO index of o_Result
//   o_Valid          one-cycle pulse when o_Result/o_Result_Idx update
//   o_Sweep_Done     one-cycle pulse at the end of each sweep
//   o_Busy           high in every state except IDLE
module ro_sweep_ctrl #(
  parameter int unsigned NUM_RO     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned WINDOW_CYC = 256,
  parameter int unsigned HOLD_CYC   = 4,
  localparam int unsigned IdxW      = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Continuous,
  input  logic [NUM_RO-1:0] i_Mask,
  input  logic [CNT_W-1:0] i_Cnt_Value,
  output logic             o_RO_Enable,
  output logic [NUM_RO-1:0] o_RO_Sel,
  output logic             o_Cnt_Clr,
  output logic             o_Cnt_Gate,
  output logic [CNT_W-1:0] o_Result,
  output logic [IdxW-1:0]  o_Result_Idx,
  output logic             o_Valid,
  output logic             o_Sweep_Done,
  output logic             o_Busy
);

  localparam int unsigned MaxSh  = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int unsigned MaxCyc = (WINDOW_CYC > MaxSh) ? WINDOW_CYC : MaxSh;
  localparam int unsigned TmrW   = (MaxCyc > 1) ? $clog2(MaxCyc + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StGate,
    StHold,
    StCapture,
    StEnd
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_RO-1:0]   mask_q, mask_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [CNT_W-1:0]    result_q, result_d;
  logic [IdxW-1:0]     result_idx_q, result_idx_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic [NUM_RO-1:0]   sel_q, sel_d;
  logic                clr_q, clr_d;
  logic                gate_q, gate_d;
  logic                busy_q, busy_d;
  logic [IdxW:0]       nxt;

  // Lowest set mask bit at index >= from; MSB of the result flags "found".
  function automatic logic [IdxW:0] first_from(input logic [NUM_RO-1:0] mask, input int from);
    logic [IdxW:0] r;
    r = '0;
    for (int i = int'(NUM_RO) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        r = {1'b1, IdxW'(i)};
      end
    end
    return r;
  endfunction

  // Next-state logic; valid/done are raised on exit from CAPTURE/END.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    tmr_d        = tmr_q;
    result_d     = result_q;
    result_idx_d = result_idx_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    nxt          = '0;
    case (state_q)
      StIdle: begin
        if (i_Start) begin
          mask_d = i_Mask;
          nxt    = first_from(i_Mask, 0);
          if (nxt[IdxW]) begin
            idx_d   = nxt[IdxW-1:0];
            state_d = StClear;
          end else begin
            state_d = StEnd;
          end
        end
      end
      StClear: begin
        tmr_d   = TmrW'(SETTLE_CYC - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (tmr_q == '0) begin
          tmr_d   = TmrW'(WINDOW_CYC - 1);
          state_d = StGate;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StGate: begin
        if (tmr_q == '0) begin
          tmr_d   = TmrW'(HOLD_CYC - 1);
          state_d = StHold;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StHold: begin
        if (tmr_q == '0) begin
          state_d = StCapture;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StCapture: begin
        valid_d      = 1'b1;
        result_d     = i_Cnt_Value;
        result_idx_d = idx_q;
        nxt          = first_from(mask_q, int'(idx_q) + 1);
        if (nxt[IdxW]) begin
          idx_d   = nxt[IdxW-1:0];
          state_d = StClear;
        end else begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        done_d = 1'b1;
        if (i_Continuous) begin
          // Restart re-latches the mask; an empty mask keeps cycling through END.
          mask_d = i_Mask;
          nxt    = first_from(i_Mask, 0);
          if (nxt[IdxW]) begin
            idx_d   = nxt[IdxW-1:0];
            state_d = StClear;
          end else begin
            state_d = StEnd;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control outputs are registered from the next state so they align with the state itself.
  always_comb begin
    sel_d  = '0;
    en_d   = 1'b0;
    clr_d  = 1'b0;
    gate_d = 1'b0;
    unique case (state_d)
      StClear: begin
        sel_d = NUM_RO'(1) << idx_d;
        clr_d = 1'b1;
      end
      StSettle: begin
        sel_d = NUM_RO'(1) << idx_d;
        en_d  = 1'b1;
      end
      StGate: begin
        sel_d  = NUM_RO'(1) << idx_d;
        en_d   = 1'b1;
        gate_d = 1'b1;
      end
      StHold, StCapture: begin
        sel_d = NUM_RO'(1) << idx_d;
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      mask_q       <= '0;
      tmr_q        <= '0;
      result_q     <= '0;
      result_idx_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      en_q         <= 1'b0;
      sel_q        <= '0;
      clr_q        <= 1'b0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      tmr_q        <= tmr_d;
      result_q     <= result_d;
      result_idx_q <= result_idx_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      en_q         <= en_d;
      sel_q        <= sel_d;
      clr_q        <= clr_d;
      gate_q       <= gate_d;
      busy_q       <= busy_d;
    end
  end

  assign o_RO_Enable  = en_q;
  assign o_RO_Sel     = sel_q;
  assign o_Cnt_Clr    = clr_q;
  assign o_Cnt_Gate   = gate_q;
  assign o_Result     = result_q;
  assign o_Result_Idx = result_idx_q;
  assign o_Valid      = valid_q;
  assign o_Sweep_Done = done_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Bench for ro_sweep_ctrl (NUM_RO=4, S=2, W=8, H=2). The expected outputs for every cycle
// of a sweep come from a timeline model: each measured RO occupies P = 2+S+W+H cycles
// counted from the cycle after the start edge. Inputs that the design must ignore
// (mid-sweep mask/continuous, i_Start while busy) are randomized.
module tb_ro_sweep_ctrl;
  localparam int S = 2;
  localparam int W = 8;
  localparam int H = 2;
  localparam int P = 2 + S + W + H;

  logic        clk;
  logic        i_Rst;
  logic        i_Start;
  logic        i_Continuous;
  logic [3:0]  i_Mask;
  logic [15:0] i_Cnt_Value;
  logic        o_RO_Enable;
  logic [3:0]  o_RO_Sel;
  logic        o_Cnt_Clr;
  logic        o_Cnt_Gate;
  logic [15:0] o_Result;
  logic [1:0]  o_Result_Idx;
  logic        o_Valid;
  logic        o_Sweep_Done;
  logic        o_Busy;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] cnt_hist[0:127];
  logic [15:0] exp_res;
  logic [1:0]  exp_idx;
  logic        prev_en;
  logic [3:0]  prev_sel;

  ro_sweep_ctrl #(
    .NUM_RO    (4),
    .CNT_W     (16),
    .SETTLE_CYC(S),
    .WINDOW_CYC(W),
    .HOLD_CYC  (H)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_Start     (i_Start),
    .i_Continuous(i_Continuous),
    .i_Mask      (i_Mask),
    .i_Cnt_Value (i_Cnt_Value),
    .o_RO_Enable (o_RO_Enable),
    .o_RO_Sel    (o_RO_Sel),
    .o_Cnt_Clr   (o_Cnt_Clr),
    .o_Cnt_Gate  (o_Cnt_Gate),
    .o_Result    (o_Result),
    .o_Result_Idx(o_Result_Idx),
    .o_Valid     (o_Valid),
    .o_Sweep_Done(o_Sweep_Done),
    .o_Busy      (o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {4'b0, o_RO_Enable, o_RO_Sel, o_Cnt_Clr, o_Cnt_Gate, o_Busy, o_Valid, o_Sweep_Done,
            o_Result, o_Result_Idx};
  endfunction

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!i_Rst) begin
      chk("clr_gate_excl", 32'(o_Cnt_Clr & o_Cnt_Gate), 32'd0);
      chk("sel_onehot0", 32'($onehot0(o_RO_Sel)), 32'd1);
      if (prev_en && o_RO_Enable) chk("sel_stable_en", 32'(o_RO_Sel), 32'(prev_sel));
    end
    prev_en  = o_RO_Enable;
    prev_sel = o_RO_Sel;
  end

  // Request a sweep from idle: sampled at the next rising edge (cycle 0).
  task automatic launch(input logic [3:0] m);
    i_Start = 1'b1;
    i_Mask  = m;
  endtask

  // One sweep with latched mask m, cycles 1 .. n*P+1 (the last is END). At END the bench
  // presents next_m/cont; din says whether the previous sweep's done pulse lands on cycle 1.
  task automatic sweep(input logic [3:0] m, input logic [3:0] next_m, input logic cont,
                       input logic din);
    int lst[4];
    int n;
    int last;
    int k;
    int ph;
    logic en, clr, gate, valid;
    logic [3:0] sel;
    logic [3:0] one;
    one = 4'b0001;
    n = 0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        lst[n] = b;
        n++;
      end
    end
    last = n * P + 1;
    for (int t = 1; t <= last; t++) begin
      @(posedge clk);
      #1;
      i_Cnt_Value = 16'($urandom);
      cnt_hist[t] = i_Cnt_Value;
      i_Start     = 1'($urandom);
      if (t == last) begin
        i_Mask       = next_m;
        i_Continuous = cont;
      end else begin
        i_Mask       = 4'($urandom);
        i_Continuous = 1'($urandom);
      end
      @(negedge clk);
      en = 0; clr = 0; gate = 0; valid = 0; sel = 4'b0;
      if (t <= n * P) begin
        k    = (t - 1) / P;
        ph   = (t - 1) % P;
        sel  = one << lst[k];
        clr  = (ph == 0);
        en   = (ph >= 1) && (ph <= S + W);
        gate = (ph > S) && (ph <= S + W);
      end
      if (t > 1 && ((t - 1) % P) == 0) begin
        valid   = 1'b1;
        exp_res = cnt_hist[t - 1];
        exp_idx = 2'(lst[(t - 1) / P - 1]);
      end
      chk($sformatf("sweep m=%b t=%0d", m, t), obs_vec(),
          {4'b0, en, sel, clr, gate, 1'b1, valid, (t == 1) && din, exp_res, exp_idx});
    end
  endtask

  task automatic idle_check(input logic din);
    @(posedge clk);
    #1;
    i_Start     = 1'b0;
    i_Cnt_Value = 16'($urandom);
    i_Mask      = 4'($urandom);
    @(negedge clk);
    chk("idle", obs_vec(), {4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, din, exp_res, exp_idx});
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] nm;
    i_Rst        = 1'b1;
    i_Start      = 1'b0;
    i_Continuous = 1'b0;
    i_Mask       = 4'b0;
    i_Cnt_Value  = 16'h0;
    exp_res      = 16'h0;
    exp_idx      = 2'd0;
    prev_en      = 1'b0;
    prev_sel     = 4'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", obs_vec(), 32'd0);
    i_Rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", obs_vec(), 32'd0);

    // Single RO, exact timing.
    launch(4'b0001);
    sweep(4'b0001, 4'b0, 1'b0, 1'b0);
    idle_check(1'b1);
    idle_check(1'b0);

    // Two ROs, ascending order.
    launch(4'b1010);
    sweep(4'b1010, 4'b0, 1'b0, 1'b0);
    idle_check(1'b1);
    idle_check(1'b0);

    // Empty mask, single and continuous.
    launch(4'b0000);
    sweep(4'b0000, 4'b0, 1'b0, 1'b0);
    idle_check(1'b1);
    idle_check(1'b0);
    launch(4'b0000);
    sweep(4'b0000, 4'b0000, 1'b1, 1'b0);
    sweep(4'b0000, 4'b0000, 1'b1, 1'b1);
    sweep(4'b0000, 4'b0100, 1'b1, 1'b1);
    sweep(4'b0100, 4'b0, 1'b0, 1'b1);
    idle_check(1'b1);
    idle_check(1'b0);

    // Continuous, then dropped.
    launch(4'b0011);
    sweep(4'b0011, 4'b0011, 1'b1, 1'b0);
    sweep(4'b0011, 4'b0011, 1'b1, 1'b1);
    sweep(4'b0011, 4'b0, 1'b0, 1'b1);
    idle_check(1'b1);
    idle_check(1'b0);

    // Mask changed mid-sweep takes effect only on the next sweep.
    launch(4'b1010);
    sweep(4'b1010, 4'b0101, 1'b1, 1'b0);
    sweep(4'b0101, 4'b0, 1'b0, 1'b1);
    idle_check(1'b1);
    idle_check(1'b0);

    // Asynchronous reset while the gate is open.
    launch(4'b0100);
    repeat (6) begin
      @(posedge clk);
      #1;
      i_Start     = 1'b0;
      i_Cnt_Value = 16'($urandom);
    end
    @(negedge clk);
    chk("gate_before_reset", 32'(o_Cnt_Gate), 32'd1);
    #2;
    i_Rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({o_RO_Enable, o_Cnt_Gate, o_RO_Sel, o_Busy}), 32'd0);
    exp_res = 16'h0;
    exp_idx = 2'd0;
    @(negedge clk);
    chk("reset_held", obs_vec(), 32'd0);
    i_Rst = 1'b0;
    launch(4'b0100);
    sweep(4'b0100, 4'b0, 1'b0, 1'b0);
    idle_check(1'b1);
    idle_check(1'b0);

    // Random continuous chain.
    m = 4'($urandom);
    launch(m);
    for (int r = 0; r < 5; r++) begin
      nm = 4'($urandom);
      sweep(m, nm, r < 4, r > 0);
      m = nm;
    end
    idle_check(1'b1);
    idle_check(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
